// File: rtl/seg_display_scheduler_pkg.sv
// Shared types and constants for the seven-segment display scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seg_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    GAP   = 2'd2,
    ALERT = 2'd3
  } sched_state_t;

  localparam int   DIGIT_W  = 4;
  localparam logic BLANK_ON = 1'b1;

endpackage

// File: rtl/seg_display_scheduler_tick_gen.sv
// Free-running prescaler producing the scheduler dwell tick.
// Latency: tick is registered and high while the count sits at TICK_DIV-1.
// Backpressure: none; never stalled by scheduler state.
module seg_tick_gen #(
  parameter logic [23:0] TICK_DIV = 24'd10_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic o_tick
);

  localparam logic [23:0] CNT_LAST = TICK_DIV - 24'd1;

  logic [23:0] r_cnt;
  logic [23:0] w_cnt_nxt;
  logic        r_tick;

  assign w_cnt_nxt = (r_cnt == CNT_LAST) ? 24'd0 : r_cnt + 24'd1;

  // Count 0..TICK_DIV-1 and flag the wrap count one cycle ahead so tick lines up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= 24'd0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_tick <= (w_cnt_nxt == CNT_LAST);
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/seg_display_scheduler.sv
// Time-slices one seven-segment digit between NUM_REQ requesters (round-robin, urgent pre-empt + blink).
// Latency: all outputs registered; grant/digit follow requests one cycle later.
// Backpressure: none; optional blank gap between owners enabled by SEG_SCHED_GAP_EN.
module seg_display_scheduler
  import seg_sched_pkg::*;
#(
  parameter int          NUM_REQ     = 4,
  parameter logic [23:0] TICK_DIV    = 24'd10_000_000,
  parameter int          DWELL_TICKS = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         urgent,
  input  logic [DIGIT_W*NUM_REQ-1:0] req_digit,
  output logic [NUM_REQ-1:0]         grant,
  output logic [DIGIT_W-1:0]         digit_out,
  output logic                       blank,
  output logic                       tick
);

  localparam int         IDX_W     = $clog2(NUM_REQ);
  localparam logic [3:0] DWELL_LIM = 4'(DWELL_TICKS);

  // First requester after 'last', wrapping; 'last' itself is tried only at the end.
  function automatic logic [IDX_W-1:0] f_rr_pick(input logic [NUM_REQ-1:0] r,
                                                input logic [IDX_W-1:0]   last);
    logic [IDX_W-1:0] pick;
    int               j;
    pick = last;
    for (int k = NUM_REQ; k >= 1; k--) begin
      j = (int'(last) + k) % NUM_REQ;
      if (r[j]) pick = IDX_W'(j);
    end
    return pick;
  endfunction

  // Lowest set index wins.
  function automatic logic [IDX_W-1:0] f_prio_pick(input logic [NUM_REQ-1:0] r);
    logic [IDX_W-1:0] pick;
    pick = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (r[k]) pick = IDX_W'(k);
    end
    return pick;
  endfunction

  function automatic logic [NUM_REQ-1:0] f_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [DIGIT_W-1:0] f_slice(input logic [DIGIT_W*NUM_REQ-1:0] d,
                                                input logic [IDX_W-1:0]           idx);
    return d[DIGIT_W*idx +: DIGIT_W];
  endfunction

  sched_state_t       r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_owner, w_owner_nxt;
  logic [IDX_W-1:0]   r_last,  w_last_nxt;
  logic [3:0]         r_dwell, w_dwell_nxt;
  logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
  logic [DIGIT_W-1:0] r_digit, w_digit_nxt;
  logic               r_blank, w_blank_nxt;

  logic               w_tick;
  logic [NUM_REQ-1:0] w_urg;
  logic               w_any_urg;
  logic               w_any_req;
  logic [IDX_W-1:0]   w_urg_idx;
  logic [IDX_W-1:0]   w_rr_idx;
  logic               w_leave;
  logic               w_arb;

  seg_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .o_tick (w_tick)
  );

  // Urgent only counts where the requester is actually asking for the display.
  assign w_urg     = req & urgent;
  assign w_any_urg = |w_urg;
  assign w_any_req = |req;
  assign w_urg_idx = f_prio_pick(w_urg);
  assign w_rr_idx  = f_rr_pick(req, r_last);

  // Next-state: urgent pre-emption overrides everything, then per-state dwell/gap handling.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_dwell_nxt = r_dwell;
    w_grant_nxt = r_grant;
    w_digit_nxt = r_digit;
    w_blank_nxt = r_blank;
    w_leave     = 1'b0;
    w_arb       = 1'b0;

    if (w_any_urg) begin
      w_state_nxt = ALERT;
      w_owner_nxt = w_urg_idx;
      w_last_nxt  = w_urg_idx;
      w_grant_nxt = f_onehot(w_urg_idx);
      w_digit_nxt = f_slice(req_digit, w_urg_idx);
      w_dwell_nxt = 4'd0;
      // A new alert owner always starts lit; an ongoing alert blinks on each tick.
      if (r_state != ALERT || r_owner != w_urg_idx) begin
        w_blank_nxt = 1'b0;
      end else if (w_tick) begin
        w_blank_nxt = ~r_blank;
      end
    end else begin
      case (r_state)
        IDLE: w_arb = 1'b1;
        SHOW: begin
          w_digit_nxt = f_slice(req_digit, r_owner);
          // Owner dropping beats a coincident tick.
          if (!req[r_owner]) begin
            w_leave = 1'b1;
          end else if (w_tick) begin
            if (r_dwell + 4'd1 == DWELL_LIM) w_leave = 1'b1;
            else                             w_dwell_nxt = r_dwell + 4'd1;
          end
        end
        GAP:     if (w_tick) w_arb = 1'b1;
        ALERT:   w_leave = 1'b1;
        default: w_arb = 1'b1;
      endcase

`ifdef SEG_SCHED_GAP_EN
      if (w_leave) begin
        w_state_nxt = GAP;
        w_grant_nxt = '0;
        w_blank_nxt = BLANK_ON;
        w_dwell_nxt = 4'd0;
      end
`else
      if (w_leave) w_arb = 1'b1;
`endif

      if (w_arb) begin
        if (w_any_req) begin
          w_state_nxt = SHOW;
          w_owner_nxt = w_rr_idx;
          w_last_nxt  = w_rr_idx;
          w_grant_nxt = f_onehot(w_rr_idx);
          w_digit_nxt = f_slice(req_digit, w_rr_idx);
          w_blank_nxt = ~BLANK_ON;
          w_dwell_nxt = 4'd0;
        end else begin
          w_state_nxt = IDLE;
          w_grant_nxt = '0;
          w_blank_nxt = BLANK_ON;
          w_dwell_nxt = 4'd0;
        end
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_last  <= '0;
      r_dwell <= 4'd0;
      r_grant <= '0;
      r_digit <= '0;
      r_blank <= BLANK_ON;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
      r_dwell <= w_dwell_nxt;
      r_grant <= w_grant_nxt;
      r_digit <= w_digit_nxt;
      r_blank <= w_blank_nxt;
    end
  end

  assign grant     = r_grant;
  assign digit_out = r_digit;
  assign blank     = r_blank;
  assign tick      = w_tick;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Directed bench for seg_display_scheduler (NUM_REQ=4, TICK_DIV=4, DWELL_TICKS=2).
// Expected output changes are queued with the cycle they must appear in; a monitor pops on every change.
// Tick is checked every cycle against the reset-aligned 4-cycle phase.
module tb_seg_display_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = 4'b0;
  logic [3:0]  urgent = 4'b0;
  logic [15:0] req_digit = 16'h0;
  logic [3:0]  grant;
  logic [3:0]  digit_out;
  logic        blank;
  logic        tick;

  seg_display_scheduler #(
    .NUM_REQ     (4),
    .TICK_DIV    (24'd4),
    .DWELL_TICKS (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .urgent    (urgent),
    .req_digit (req_digit),
    .grant     (grant),
    .digit_out (digit_out),
    .blank     (blank),
    .tick      (tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] g;
    logic [3:0] d;
    logic       b;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_mis = 0;
  logic mon_en = 1'b0;
  logic [8:0] prev;

  // Cycle index since reset release; the prescaler phase equals cyc % 4.
  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  task automatic ex(input int c, input logic [3:0] g, input logic [3:0] d, input logic b);
    exp_t e;
    e.cyc = c; e.g = g; e.d = d; e.b = b;
    q.push_back(e);
  endtask

  // Advance to just after the edge that starts cycle n.
  task automatic go(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic exp_tick;
    if (mon_en) begin
      exp_tick = ((cyc % 4) == 3);
      n_vec++;
      if (tick !== exp_tick) begin
        n_mis++;
        $display("FAIL tick cyc=%0d got=%b want=%b", cyc, tick, exp_tick);
      end
      if ({grant, digit_out, blank} !== prev) begin
        n_vec++;
        if (q.size() == 0) begin
          n_mis++;
          $display("FAIL unexpected_change cyc=%0d got grant=%b digit=%0d blank=%b",
                   cyc, grant, digit_out, blank);
        end else begin
          e = q.pop_front();
          if (e.cyc != cyc || e.g !== grant || e.d !== digit_out || e.b !== blank) begin
            n_mis++;
            $display("FAIL change cyc=%0d grant=%b digit=%0d blank=%b want cyc=%0d grant=%b digit=%0d blank=%b",
                     cyc, grant, digit_out, blank, e.cyc, e.g, e.d, e.b);
          end
        end
        prev = {grant, digit_out, blank};
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    n_vec++;
    if (grant !== 4'b0000 || digit_out !== 4'd0 || blank !== 1'b1 || tick !== 1'b0) begin
      n_mis++;
      $display("FAIL reset_state grant=%b digit=%0d blank=%b tick=%b want 0000/0/1/0",
               grant, digit_out, blank, tick);
    end
    prev   = {grant, digit_out, blank};
    mon_en = 1'b1;

    // Two requesters 0 and 2: first search starts at idx1, so idx2 wins.
    go(12);
    req_digit = 16'h0703;
    req       = 4'b0101;
    ex(13, 4'b0100, 4'd7, 1'b0);
`ifdef SEG_SCHED_GAP_EN
    ex(20, 4'b0000, 4'd7, 1'b1);
    ex(24, 4'b0001, 4'd3, 1'b0);
    ex(32, 4'b0000, 4'd3, 1'b1);
    ex(36, 4'b0100, 4'd7, 1'b0);
    go(37); req_digit = 16'h0909;
    ex(38, 4'b0100, 4'd9, 1'b0);
`else
    ex(20, 4'b0001, 4'd3, 1'b0);
    ex(28, 4'b0100, 4'd7, 1'b0);
    ex(36, 4'b0001, 4'd3, 1'b0);
    go(37); req_digit = 16'h0909;
    ex(38, 4'b0001, 4'd9, 1'b0);
`endif
    go(39); req = 4'b0000;
    ex(40, 4'b0000, 4'd9, 1'b1);

    // Lone requester 3 keeps being re-granted.
    go(48);
    req_digit = 16'h5000;
    req       = 4'b1000;
    ex(49, 4'b1000, 4'd5, 1'b0);
`ifdef SEG_SCHED_GAP_EN
    ex(56, 4'b0000, 4'd5, 1'b1);
    ex(60, 4'b1000, 4'd5, 1'b0);
    ex(68, 4'b0000, 4'd5, 1'b1);
    ex(72, 4'b1000, 4'd5, 1'b0);
`endif
    go(73); req = 4'b0000;
    ex(74, 4'b0000, 4'd5, 1'b1);

    // Idx2 showing, then idx1 goes urgent: alert with blink, then back to round-robin.
    go(80);
    req_digit = 16'h0710;
    req       = 4'b0100;
    ex(81, 4'b0100, 4'd7, 1'b0);
    go(82);
    req    = 4'b0110;
    urgent = 4'b0010;
    ex(83, 4'b0010, 4'd1, 1'b0);
    ex(84, 4'b0010, 4'd1, 1'b1);
    ex(88, 4'b0010, 4'd1, 1'b0);
    ex(92, 4'b0010, 4'd1, 1'b1);
    go(93); urgent = 4'b0000;
`ifdef SEG_SCHED_GAP_EN
    ex(94, 4'b0000, 4'd1, 1'b1);
    ex(96, 4'b0100, 4'd7, 1'b0);
`else
    ex(94, 4'b0100, 4'd7, 1'b0);
`endif
    go(97); req = 4'b0000;
    ex(98, 4'b0000, 4'd7, 1'b1);

    // Urgent idx3, then lower-index idx1 takes over; reset mid-alert.
    go(104);
    req_digit = 16'h8010;
    req       = 4'b1010;
    urgent    = 4'b1000;
    ex(105, 4'b1000, 4'd8, 1'b0);
    go(105); urgent = 4'b1010;
    ex(106, 4'b0010, 4'd1, 1'b0);
    ex(108, 4'b0010, 4'd1, 1'b1);
    go(109); reset = 1'b1;
    ex(0, 4'b0000, 4'd0, 1'b1);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    urgent = 4'b0000;
    req    = 4'b0000;

    // After reset the pointer is back to 0: idx1 wins over idx0.
    go(4);
    req_digit = 16'h0021;
    req       = 4'b0011;
    ex(5, 4'b0010, 4'd2, 1'b0);
    go(6); req = 4'b0000;
    ex(7, 4'b0000, 4'd2, 1'b1);
    go(12);

    while (q.size() > 0) begin
      e = q.pop_front();
      n_vec++;
      n_mis++;
      $display("FAIL missing_change want cyc=%0d grant=%b digit=%0d blank=%b", e.cyc, e.g, e.d, e.b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
